// File: rtl/ifetch_buffer_pkg.sv
// Shared types for the instruction-fetch buffer.
//   common : instruction-bus request/response structs shared with the bus fabric.
//   pipes  : fetch-queue entry and fetch FSM state used inside the front end.
package common;

    // Instruction bus request. The fetch unit only drives valid and addr.
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
    } ibus_req_t;

    // Instruction bus response. data_ok marks completion and qualifies data.
    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

package pipes;

    // One instruction-queue entry.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch FSM.
    //   IDLE : no request outstanding
    //   WAIT : request outstanding, response will be queued
    //   DROP : request outstanding, response will be discarded (stale after redirect)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Force a fetch address onto a 4-byte boundary.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_buffer_fifo.sv
// ifetch_fifo: DEPTH-entry ring buffer holding fetched instructions.
//   clk, reset : clock and asynchronous active-low reset
//   flush      : empties the queue; overrides push and pop in the same cycle
//   push       : write push_entry at the tail (caller guarantees space)
//   pop        : consume the head entry (ignored when empty)
//   head_valid : queue is non-empty
//   head_entry : entry at the head, read straight from storage registers
//   count      : current occupancy, 0..DEPTH
module ifetch_fifo
    import pipes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output logic                     head_valid,
    output fetch_entry_t             head_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && (count != '0) && !flush;

    // Pointers are exactly log2(DEPTH) bits, so the increment wraps modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it was written,
    // which count/head_valid guarantee, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_entry;
    end

    assign head_valid = (count != '0);
    assign head_entry = mem[head];

endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: sequential instruction fetcher with a small instruction queue.
//   clk, reset      : clock and asynchronous active-low reset
//   ireq            : instruction bus request (valid, addr); held stable until data_ok
//   iresp           : instruction bus response (data_ok, 32-bit data)
//   redirect_valid  : flush the queue and restart fetch at redirect_pc
//   redirect_pc     : new fetch address, low two bits ignored
//   out_valid       : queue head holds an instruction
//   out_pc          : PC of the queue head
//   out_instr       : instruction at the queue head
//   out_ready       : consumer takes the head this cycle
//   count           : queue occupancy
// At most one request is outstanding. A request is only issued when a queue slot
// is guaranteed for its response, so the queue can never overflow.
module ifetch_buffer
    import common::*;
    import pipes::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output ibus_req_t                ireq,
    input  ibus_resp_t               iresp,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state;
    logic [63:0]   fetch_pc;
    logic [63:0]   req_addr;

    logic          deq;
    logic          push;
    logic [CW:0]   occ_after_pop;
    logic          space_idle;
    logic          space_after_push;
    logic [63:0]   redirect_aligned;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic          unused_redirect_low;

    assign redirect_aligned    = align_pc(redirect_pc);
    assign unused_redirect_low = &{1'b0, redirect_pc[1:0]};

    // Pop only takes effect without a redirect; the FIFO applies that priority.
    assign deq  = out_valid && out_ready;
    assign push = (state == WAIT) && iresp.data_ok && !redirect_valid;

    // Occupancy seen by the issue logic once this cycle's pop has happened.
    // From IDLE nothing is outstanding, so a free slot means count - deq < DEPTH.
    // From WAIT the response being pushed also takes a slot before the next issue.
    assign occ_after_pop    = {1'b0, count} - {{CW{1'b0}}, deq};
    assign space_idle       = occ_after_pop < DEPTH_W;
    assign space_after_push = (occ_after_pop + (CW + 1)'(1)) < DEPTH_W;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_aligned;
                    end else if (space_idle) begin
                        req_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        // The outstanding request cannot be withdrawn; its response
                        // is stale. If it lands this very cycle it is simply ignored.
                        fetch_pc <= redirect_aligned;
                        state    <= iresp.data_ok ? IDLE : DROP;
                    end else if (iresp.data_ok) begin
                        fetch_pc <= req_addr + 64'd4;
                        if (space_after_push) begin
                            req_addr <= req_addr + 64'd4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect_valid) fetch_pc <= redirect_aligned;
                    if (iresp.data_ok)  state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every field gets a default before the conditional-free overrides so
    // the block stays purely combinational with no inferred latch.
    always_comb begin
        ireq       = '0;
        ireq.valid = (state == WAIT) || (state == DROP);
        ireq.addr  = req_addr;
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = req_addr;
        push_entry.instr = iresp.data;
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (deq),
        .head_valid (out_valid),
        .head_entry (head_entry),
        .count      (count)
    );

    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: a DEPTH=4 instance for the fetch/redirect/reset
// sequences and a DEPTH=2 instance for wrap-around with random response stalls.
// The instruction memory model returns addr[31:0] + 0x13 for every fetch.
module tb_ifetch_buffer;
    import common::*;

    logic clk = 1'b0;
    logic reset;

    // DEPTH=4 instance
    ibus_req_t   ireq4;
    ibus_resp_t  iresp4;
    logic        ok4, rdy4, rv4;
    logic [63:0] rpc4;
    logic        out_valid4;
    logic [63:0] out_pc4;
    logic [31:0] out_instr4;
    logic [2:0]  count4;

    // DEPTH=2 instance
    ibus_req_t   ireq2;
    ibus_resp_t  iresp2;
    logic        ok2, rdy2, rv2;
    logic [63:0] rpc2;
    logic        out_valid2;
    logic [63:0] out_pc2;
    logic [31:0] out_instr2;
    logic [1:0]  count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign iresp4 = '{data_ok: ok4, data: ireq4.addr[31:0] + 32'h13};
    assign iresp2 = '{data_ok: ok2, data: ireq2.addr[31:0] + 32'h13};

    ifetch_buffer #(.DEPTH(4), .RESET_PC(64'h8000_0000)) u4 (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq4),
        .iresp          (iresp4),
        .redirect_valid (rv4),
        .redirect_pc    (rpc4),
        .out_valid      (out_valid4),
        .out_pc         (out_pc4),
        .out_instr      (out_instr4),
        .out_ready      (rdy4),
        .count          (count4)
    );

    ifetch_buffer #(.DEPTH(2), .RESET_PC(64'h8000_0000)) u2 (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq2),
        .iresp          (iresp2),
        .redirect_valid (rv2),
        .redirect_pc    (rpc2),
        .out_valid      (out_valid2),
        .out_pc         (out_pc2),
        .out_instr      (out_instr2),
        .out_ready      (rdy2),
        .count          (count2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [63:0] exp_pc;
        int          pops;

        reset = 1'b0;
        ok4 = 1'b0; rdy4 = 1'b0; rv4 = 1'b0; rpc4 = '0;
        ok2 = 1'b0; rdy2 = 1'b1; rv2 = 1'b0; rpc2 = '0;

        // Held in reset
        tick(); tick();
        check("rst_ireq_valid", ireq4.valid, 0);
        check("rst_count",      count4, 0);
        check("rst_out_valid",  out_valid4, 0);

        // Release, response every cycle, no consumer: four requests then stop
        reset = 1'b1; ok4 = 1'b1;
        tick();
        check("fill_req0_valid", ireq4.valid, 1);
        check("fill_req0_addr",  ireq4.addr, 64'h8000_0000);
        check("fill_req0_count", count4, 0);
        tick();
        check("fill_req1_addr",  ireq4.addr, 64'h8000_0004);
        check("fill_count1",     count4, 1);
        check("fill_head_valid", out_valid4, 1);
        check("fill_head_pc",    out_pc4, 64'h8000_0000);
        check("fill_head_instr", out_instr4, 32'h8000_0013);
        tick();
        check("fill_req2_addr",  ireq4.addr, 64'h8000_0008);
        check("fill_count2",     count4, 2);
        tick();
        check("fill_req3_addr",  ireq4.addr, 64'h8000_000C);
        check("fill_count3",     count4, 3);
        tick();
        check("full_no_req",     ireq4.valid, 0);
        check("full_count4",     count4, 4);
        tick();
        check("full_still_idle", ireq4.valid, 0);
        check("full_still_4",    count4, 4);
        check("full_head_pc",    out_pc4, 64'h8000_0000);

        // One pop frees a slot: issue from IDLE in the same cycle
        ok4 = 1'b0; rdy4 = 1'b1;
        tick();
        check("pop_count3",      count4, 3);
        check("pop_req_valid",   ireq4.valid, 1);
        check("pop_req_addr",    ireq4.addr, 64'h8000_0010);
        check("pop_head_pc",     out_pc4, 64'h8000_0004);
        check("pop_head_instr",  out_instr4, 32'h8000_0017);
        rdy4 = 1'b0; ok4 = 1'b1;
        tick();
        check("refill_count4",   count4, 4);
        check("refill_idle",     ireq4.valid, 0);
        ok4 = 1'b0; rdy4 = 1'b1;
        tick();
        check("pop2_req_addr",   ireq4.addr, 64'h8000_0014);
        check("pop2_req_valid",  ireq4.valid, 1);

        // Asynchronous reset while a request is outstanding
        rdy4 = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid",     ireq4.valid, 0);
        check("async_rst_count",     count4, 0);
        check("async_rst_out_valid", out_valid4, 0);
        tick();
        check("in_rst_valid",        ireq4.valid, 0);
        reset = 1'b1;
        tick();
        check("post_rst_valid",      ireq4.valid, 1);
        check("post_rst_addr",       ireq4.addr, 64'h8000_0000);

        // Redirect while waiting on 0x80000008, response three cycles later
        ok4 = 1'b1;
        tick(); tick();
        check("pre_redir_addr",  ireq4.addr, 64'h8000_0008);
        check("pre_redir_count", count4, 2);
        ok4 = 1'b0; rv4 = 1'b1; rpc4 = 64'h8000_1000;
        tick();
        check("drop_valid",      ireq4.valid, 1);
        check("drop_addr",       ireq4.addr, 64'h8000_0008);
        check("drop_count",      count4, 0);
        check("drop_out_valid",  out_valid4, 0);
        rv4 = 1'b0;
        tick();
        check("drop_hold_addr1", ireq4.addr, 64'h8000_0008);
        check("drop_hold_cnt1",  count4, 0);
        tick();
        check("drop_hold_addr2", ireq4.addr, 64'h8000_0008);
        ok4 = 1'b1;
        tick();
        check("drop_done_idle",  ireq4.valid, 0);
        check("drop_done_count", count4, 0);
        ok4 = 1'b0;
        tick();
        check("redir_req_valid", ireq4.valid, 1);
        check("redir_req_addr",  ireq4.addr, 64'h8000_1000);

        // Redirect coinciding with data_ok and a pop: no push, no pop, queue flushed
        ok4 = 1'b1;
        tick();
        check("pre_rp_count",    count4, 1);
        check("pre_rp_head",     out_pc4, 64'h8000_1000);
        ok4 = 1'b1; rdy4 = 1'b1; rv4 = 1'b1; rpc4 = 64'h8000_2002;
        tick();
        check("rp_count",        count4, 0);
        check("rp_out_valid",    out_valid4, 0);
        check("rp_idle",         ireq4.valid, 0);
        ok4 = 1'b0; rdy4 = 1'b0; rv4 = 1'b0;
        tick();
        check("rp_next_valid",   ireq4.valid, 1);
        check("rp_next_addr",    ireq4.addr, 64'h8000_2000);

        // Repeated redirects while dropping: the latest one wins
        rv4 = 1'b1; rpc4 = 64'h8000_3000;
        tick();
        check("dd_addr1",        ireq4.addr, 64'h8000_2000);
        rpc4 = 64'h8000_4000;
        tick();
        check("dd_addr2",        ireq4.addr, 64'h8000_2000);
        check("dd_valid2",       ireq4.valid, 1);
        rv4 = 1'b0; ok4 = 1'b1;
        tick();
        check("dd_idle",         ireq4.valid, 0);
        ok4 = 1'b0;
        tick();
        check("dd_next_addr",    ireq4.addr, 64'h8000_4000);

        // Redirect in the same cycle DROP completes
        rv4 = 1'b1; rpc4 = 64'h8000_7000;
        tick();
        check("dr_drop_addr",    ireq4.addr, 64'h8000_4000);
        rpc4 = 64'h8000_5000; ok4 = 1'b1;
        tick();
        check("dr_idle",         ireq4.valid, 0);
        check("dr_count",        count4, 0);
        rv4 = 1'b0; ok4 = 1'b0;
        tick();
        check("dr_next_valid",   ireq4.valid, 1);
        check("dr_next_addr",    ireq4.addr, 64'h8000_5000);

        // DEPTH=2: random response stalls with a consumer that always accepts
        exp_pc = 64'h8000_0000;
        pops   = 0;
        for (int cyc = 0; cyc < 400 && pops < 10; cyc++) begin
            ok2 = 1'($urandom_range(0, 1));
            check("d2_count_le2", (count2 <= 2'd2), 1);
            if (out_valid2) begin
                check("d2_out_pc",    out_pc2, exp_pc);
                check("d2_out_instr", out_instr2, exp_pc[31:0] + 32'h13);
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            tick();
        end
        check("d2_pops", pops, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
